// File: rtl/sccb_config_controller.sv
// SCCB write-only master that replays the OV7670 QVGA/RGB565 register table after reset or on start.
// Define CAM_COLOR_BAR_EN to append the COM17 colour-bar test pattern write before the terminator.
//
// state  | meaning
// IDLE   | bus idle, waiting for start or the post-reset auto start
// FETCH  | read table[cfg_index] and decide write / delay / end
// START  | START condition, 4 quarters
// BIT    | 27 bits (ID, register, data, each followed by a released ACK bit)
// STOP   | STOP condition, 4 quarters
// GAP    | bus idle for 4 quarters between writes
// DELAY  | bus idle for DELAY_CYCLES after a delay entry
// DONE   | table finished, waiting for start
module sccb_config_controller #(
    parameter int         CLK_FREQ_HZ  = 100_000_000,
    parameter int         SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         DELAY_CYCLES = 1_000_000,
    parameter bit         AUTO_START   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [5:0] cfg_index
);
    localparam int QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int DW  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    generate
        if (QTR < 1) begin : g_qtr_check
            $error("sccb_config_controller: CLK_FREQ_HZ too low for SCCB_FREQ_HZ");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_BIT, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    function automatic logic [15:0] table_entry(input logic [5:0] idx);
        case (idx)
            6'd0: table_entry = 16'h1280;
            6'd1: table_entry = 16'hFFF0;
            6'd2: table_entry = 16'h1214;
            6'd3: table_entry = 16'h40D0;
            6'd4: table_entry = 16'h8C00;
            6'd5: table_entry = 16'h1101;
            6'd6: table_entry = 16'h3A04;
`ifdef CAM_COLOR_BAR_EN
            6'd7: table_entry = 16'h4208;
`endif
            default: table_entry = 16'hFFFF;
        endcase
    endfunction

    state_t          state;
    logic [QW-1:0]   qtr_cnt;
    logic [1:0]      quarter;
    logic [4:0]      bit_cnt;
    logic [26:0]     shreg;
    logic [DW-1:0]   delay_cnt;
    logic            auto_go;
    logic [15:0]     entry;
    logic            tick;

    assign entry  = table_entry(cfg_index);
    assign tick   = (qtr_cnt == '0);
    assign siod_o = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            qtr_cnt   <= '0;
            quarter   <= 2'd0;
            bit_cnt   <= 5'd0;
            shreg     <= '0;
            delay_cnt <= '0;
            auto_go   <= AUTO_START;
            sioc      <= 1'b1;
            siod_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_index <= 6'd0;
        end else begin
            if (state inside {S_START, S_BIT, S_STOP, S_GAP}) begin
                qtr_cnt <= tick ? QW'(QTR - 1) : qtr_cnt - QW'(1);
                if (tick) quarter <= quarter + 2'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start || auto_go) begin
                        auto_go   <= 1'b0;
                        busy      <= 1'b1;
                        cfg_index <= 6'd0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (entry == 16'hFFFF) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (entry == 16'hFFF0) begin
                        delay_cnt <= DW'(DELAY_CYCLES - 1);
                        state     <= S_DELAY;
                    end else begin
                        // ACK slots are stored as 1 so they shift out as "released"
                        shreg   <= {DEV_ADDR, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
                        quarter <= 2'd0;
                        qtr_cnt <= QW'(QTR - 1);
                        sioc    <= 1'b1;
                        siod_oe <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        case (quarter)
                            2'd0: siod_oe <= 1'b1;
                            2'd1: sioc    <= 1'b0;
                            2'd2: ;
                            default: begin
                                bit_cnt <= 5'd0;
                                siod_oe <= ~shreg[26];
                                state   <= S_BIT;
                            end
                        endcase
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        case (quarter)
                            2'd0: ;
                            2'd1: sioc <= 1'b1;
                            2'd2: ;
                            default: begin
                                sioc <= 1'b0;
                                if (bit_cnt == 5'd26) begin
                                    siod_oe <= 1'b1;
                                    state   <= S_STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + 5'd1;
                                    shreg   <= {shreg[25:0], 1'b0};
                                    siod_oe <= ~shreg[25];
                                end
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        case (quarter)
                            2'd0: sioc    <= 1'b1;
                            2'd1: siod_oe <= 1'b0;
                            2'd2: ;
                            default: state <= S_GAP;
                        endcase
                    end
                end
                S_GAP: begin
                    if (tick && quarter == 2'd3) begin
                        cfg_index <= cfg_index + 6'd1;
                        state     <= S_FETCH;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == '0) begin
                        cfg_index <= cfg_index + 6'd1;
                        state     <= S_FETCH;
                    end else begin
                        delay_cnt <= delay_cnt - DW'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        cfg_index <= 6'd0;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_config_controller.sv
// Bench for sccb_config_controller: SCCB slave decoder feeding a scoreboard of expected register writes.
// Runs the auto-start instance through ignored/accepted starts and a mid-write reset, then an AUTO_START=0 instance.
`timescale 1ns/1ps
module tb_sccb_config_controller;
    localparam int CLK_HZ  = 400;
    localparam int SCCB_HZ = 100;
    localparam int DLY     = 20;
`ifdef CAM_COLOR_BAR_EN
    localparam int NW = 7;
`else
    localparam int NW = 6;
`endif
    // FETCH-entry edge to done: write0, delay entry, remaining writes, terminator fetch
    localparam int RUN_CYC = 1 + NW * 121 + 21;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0;
    logic reset_m = 1'b1, start_m = 1'b0;
    logic sioc, siod_o, siod_oe, busy, done;
    logic [5:0] cfg_index;
    logic sioc_m, siod_o_m, siod_oe_m, busy_m, done_m;
    logic [5:0] cfg_index_m;

    int n_tests = 0, n_fail = 0, cyc = 0, writes = 0, stops_m = 0;
    logic [15:0] exp_q[$];
    int start_cyc_q[$];

    sccb_config_controller #(.CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .DEV_ADDR(8'h42),
                             .DELAY_CYCLES(DLY), .AUTO_START(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .sioc(sioc), .siod_o(siod_o),
        .siod_oe(siod_oe), .busy(busy), .done(done), .cfg_index(cfg_index));

    sccb_config_controller #(.CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .DEV_ADDR(8'h42),
                             .DELAY_CYCLES(DLY), .AUTO_START(1'b0)) dut_m (
        .clk(clk), .reset(reset_m), .start(start_m), .sioc(sioc_m), .siod_o(siod_o_m),
        .siod_oe(siod_oe_m), .busy(busy_m), .done(done_m), .cfg_index(cfg_index_m));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] exp_write(input int i);
        case (i)
            0: exp_write = 16'h1280;
            1: exp_write = 16'h1214;
            2: exp_write = 16'h40D0;
            3: exp_write = 16'h8C00;
            4: exp_write = 16'h1101;
            5: exp_write = 16'h3A04;
            default: exp_write = 16'h4208;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        for (int i = 0; i < NW; i++) exp_q.push_back(exp_write(i));
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (done) begin
                at = cyc;
                break;
            end
        end
        check("done_within_budget", int'(done), 1);
    endtask

    // SCCB slave model / monitor for the auto-start instance
    logic p_sioc = 1'b1, p_siod = 1'b1, in_frame = 1'b0;
    int nbits = 0;
    logic [26:0] frame = '0;
    always @(negedge clk) begin : monitor
        logic cur;
        logic [15:0] e;
        cur = ~siod_oe;
        if (reset) begin
            in_frame = 1'b0;
        end else if (p_sioc && sioc && p_siod && !cur) begin
            check("start_outside_frame", int'(in_frame), 0);
            in_frame = 1'b1;
            nbits = 0;
            start_cyc_q.push_back(cyc);
        end else if (p_sioc && sioc && !p_siod && cur) begin
            check("stop_inside_frame", int'(in_frame), 1);
            check("bits_before_stop", nbits, 27);
            if (in_frame && nbits == 27) begin
                writes++;
                check("ack_slots_released", int'({frame[18], frame[9], frame[0]}), 3'b111);
                check("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_bytes", int'({frame[26:19], frame[17:10], frame[8:1]}),
                          int'({8'h42, e}));
                end
            end
            in_frame = 1'b0;
        end else if (!p_sioc && sioc && in_frame && nbits < 27) begin
            frame = {frame[25:0], cur};
            nbits++;
        end
        p_sioc = sioc;
        p_siod = cur;
    end

    logic pm_sioc = 1'b1, pm_siod = 1'b1;
    always @(negedge clk) begin
        if (!reset_m && pm_sioc && sioc_m && !pm_siod && !siod_oe_m) stops_m++;
        pm_sioc = sioc_m;
        pm_siod = ~siod_oe_m;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, e, at, bad;
        repeat (3) tick();
        check("rst_sioc", int'(sioc), 1);
        check("rst_siod_oe", int'(siod_oe), 0);
        check("rst_siod_o", int'(siod_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_index", int'(cfg_index), 0);

        // Auto start with an ignored start pulse during write of index 3
        reset = 1'b0;
        r0 = cyc + 1;
        push_run();
        while (cyc < r0 + 300) tick();
        check("cfg_index_mid_run", int'(cfg_index), 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_ignored_start", int'(busy), 1);
        check("cfg_index_after_ignored_start", int'(cfg_index), 3);
        wait_done(at);
        check("auto_run_cycles", at - r0, RUN_CYC);
        check("busy_low_at_done", int'(busy), 0);
        check("cfg_index_at_terminator", int'(cfg_index), NW + 1);
        check("writes_run1", writes, NW);
        check("queue_empty_run1", exp_q.size(), 0);
        check("start_events_run1", start_cyc_q.size(), NW);
        if (start_cyc_q.size() >= 3) begin
            check("first_start_cycle", start_cyc_q[0] - r0, 2);
            check("delay_gap", start_cyc_q[1] - start_cyc_q[0], 121 + 21);
            check("write_period", start_cyc_q[2] - start_cyc_q[1], 121);
        end
        repeat (5) tick();
        check("done_sticky", int'(done), 1);

        // Restart after done
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        e = cyc;
        check("restart_done_low", int'(done), 0);
        check("restart_busy", int'(busy), 1);
        check("restart_cfg_index", int'(cfg_index), 0);
        wait_done(at);
        check("restart_run_cycles", at - e, RUN_CYC);
        check("writes_run2", writes, 2 * NW);
        check("queue_empty_run2", exp_q.size(), 0);

        // Reset during the BIT phase of the third write, then auto replay
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        e = cyc;
        while (cyc < e + 300) tick();
        check("writes_before_reset", writes, 2 * NW + 2);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("midreset_sioc", int'(sioc), 1);
        check("midreset_siod_oe", int'(siod_oe), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_cfg_index", int'(cfg_index), 0);
        repeat (2) tick();
        reset = 1'b0;
        r0 = cyc + 1;
        push_run();
        wait_done(at);
        check("replay_run_cycles", at - r0, RUN_CYC);
        check("writes_run3", writes, 3 * NW + 2);
        check("queue_empty_run3", exp_q.size(), 0);

        // AUTO_START=0 instance: idle until start, then a normal run
        reset_m = 1'b0;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (!sioc_m || siod_oe_m || busy_m || done_m) bad++;
        end
        check("manual_idle_cycles_bad", bad, 0);
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        e = cyc;
        check("manual_busy", int'(busy_m), 1);
        at = -1;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (done_m) begin
                at = cyc;
                break;
            end
        end
        check("manual_done_within_budget", int'(done_m), 1);
        check("manual_run_cycles", at - e, RUN_CYC);
        check("manual_stop_count", stops_m, NW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
